// File: rtl/res_disp_if.sv
// res_disp_if: result handshake from the comparator/adder stage plus the
// multiplexed 7-segment display drive. The master side produces `s`/`s_valid`
// and observes status and display outputs; the slave side is res_disp.
interface res_disp_if;
  logic [4:0] s;
  logic       s_valid;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output s, s_valid,
    input  busy, done, an, seg, dp
  );

  modport slave (
    input  s, s_valid,
    output busy, done, an, seg, dp
  );
endinterface

// File: rtl/res_disp.sv
// res_disp: converts a 5-bit result (0..31) into two display digits with an
// iterative double-dabble FSM and drives an active-low, time-multiplexed
// 4-digit 7-segment display (units on digit 0, tens on digit 1).
//
// Optional build macro HEX_MODE_EN: when defined, the display shows the
// captured value in hexadecimal (tens = s[4], units = s[3:0]) while keeping
// the decimal-mode FSM timing unchanged.
module res_disp #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic       clk,
  input logic       rst_n,
  res_disp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LAST_ITER = 3'd4;

  state_t     state;
  logic [4:0] shift_q;
  logic [1:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [2:0] iter;
  logic       busy_q;
  logic       done_q;
  logic [3:0] disp_tens;
  logic [3:0] disp_units;
  logic [15:0] scan_cnt;
  logic       sel_tens;
  logic [3:0] an_q;
  logic [6:0] seg_q;
`ifdef HEX_MODE_EN
  logic [4:0] s_cap;
`endif

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'h0:    r = 7'b1000000;
      4'h1:    r = 7'b1111001;
      4'h2:    r = 7'b0100100;
      4'h3:    r = 7'b0110000;
      4'h4:    r = 7'b0011001;
      4'h5:    r = 7'b0010010;
      4'h6:    r = 7'b0000010;
      4'h7:    r = 7'b1111000;
      4'h8:    r = 7'b0000000;
      4'h9:    r = 7'b0010000;
      4'hA:    r = 7'b0001000;
      4'hB:    r = 7'b0000011;
      4'hC:    r = 7'b1000110;
      4'hD:    r = 7'b0100001;
      4'hE:    r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  // Add-3 correction applied to a BCD digit before it is doubled.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble iteration on {tens, units, shift}. Tens never exceeds 3
  // for a 5-bit input, so it needs no correction and its MSB never overflows.
  function automatic logic [10:0] dd_step(input logic [1:0] t,
                                          input logic [3:0] u,
                                          input logic [4:0] sh);
    logic [10:0] v;
    v = {t, add3(u), sh};
    return {v[9:0], 1'b0};
  endfunction

  // Conversion FSM: capture, five shift-add-3 iterations, then display load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      bcd_tens   <= '0;
      bcd_units  <= '0;
      iter       <= '0;
      disp_tens  <= '0;
      disp_units <= '0;
`ifdef HEX_MODE_EN
      s_cap      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            shift_q   <= bus.s;
            bcd_tens  <= '0;
            bcd_units <= '0;
            iter      <= '0;
            busy_q    <= 1'b1;
`ifdef HEX_MODE_EN
            s_cap     <= bus.s;
`endif
            state     <= CONV;
          end
        end
        CONV: begin
          {bcd_tens, bcd_units, shift_q} <= dd_step(bcd_tens, bcd_units, shift_q);
          iter <= iter + 3'd1;
          if (iter == LAST_ITER) state <= LOAD;
        end
        LOAD: begin
`ifdef HEX_MODE_EN
          disp_tens  <= {3'b000, s_cap[4]};
          disp_units <= s_cap[3:0];
`else
          disp_tens  <= {2'b00, bcd_tens};
          disp_units <= bcd_units;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan divider; each wrap hands the display to the other digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel_tens <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel_tens <= ~sel_tens;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Registered anode/segment drive with leading-zero blanking of the tens digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else if (!sel_tens) begin
      an_q  <= 4'b1110;
      seg_q <= seg_decode(disp_units);
    end else if (disp_tens == 4'd0) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= 4'b1101;
      seg_q <= seg_decode(disp_tens);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_res_disp.sv
// tb_res_disp: directed bench for res_disp with SCAN_DIV=4. Expected digits
// are pushed to a scoreboard when a result is offered and popped when the DUT
// signals done; display slots are then checked against the decode table.
module tb_res_disp;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t cur;
  exp_t zero_exp = '0;
  int   us, ts;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  res_disp_if bus();

  res_disp #(.SCAN_DIV(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] v);
    exp_t r;
`ifdef HEX_MODE_EN
    r.tens  = {3'b000, v[4]};
    r.units = v[3:0];
`else
    r.tens  = 4'(int'(v) / 10);
    r.units = 4'(int'(v) % 10);
`endif
    return r;
  endfunction

  function automatic logic [10:0] tens_drive(input exp_t e);
    return (e.tens == 4'd0) ? {4'b1111, 7'b1111111} : {4'b1101, dec_tab[e.tens]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] v);
    bus.s       = v;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Finds the units slot, then the tens slot, and measures the tens slot length.
  task automatic check_display(input string tag, input exp_t e);
    int n;
    n = 0;
    while (bus.an !== 4'b1110 && n < 20) begin tick(); n++; end
    chk({tag, "_units"}, 32'({bus.an, bus.seg, bus.dp}), 32'({4'b1110, dec_tab[e.units], 1'b1}));
    n = 0;
    while (bus.an === 4'b1110 && n < 20) begin tick(); n++; end
    chk({tag, "_tens"}, 32'({bus.an, bus.seg}), 32'(tens_drive(e)));
    n = 0;
    while (bus.an !== 4'b1110 && n < 20) begin tick(); n++; end
    chk({tag, "_slot_len"}, 32'(n), 32'd4);
  endtask

  // One isolated conversion with latency and done-pulse checks.
  task automatic run_conv(input logic [4:0] v, input string tag);
    exp_t e;
    sb.push_back(model(v));
    pulse(v);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_busy"}, 32'({bus.busy, bus.done}), 32'(2'b10));
      tick();
    end
    chk({tag, "_done"}, 32'({bus.busy, bus.done}), 32'(2'b01));
    tick();
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    pop_exp(tag, e);
    check_display(tag, e);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s       = '0;
    bus.s_valid = 1'b0;
    repeat (3) tick();
    chk("reset", 32'({bus.an, bus.seg, bus.dp, bus.busy, bus.done}),
        32'({4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0}));

    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("idle_status", 32'({bus.busy, bus.done}), 32'd0);
      tick();
    end
    check_display("idle", zero_exp);

    run_conv(5'd23, "dec23");
    run_conv(5'd7,  "blank7");
    run_conv(5'd0,  "zero");

    // Overlap: 31 accepted, 5 ignored while busy, 10 accepted in the done cycle.
    sb.push_back(model(5'd31));
    pulse(5'd31);
    tick();
    tick();
    pulse(5'd5);
    chk("ovl_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    tick();
    chk("ovl_done1", 32'({bus.busy, bus.done}), 32'(2'b01));
    pop_exp("ovl1", cur);
    sb.push_back(model(5'd10));
    pulse(5'd10);
    us = 0;
    ts = 0;
    for (int i = 0; i < 6; i++) begin
      chk("ovl_run", 32'({bus.busy, bus.done}), 32'(2'b10));
      if (bus.an === 4'b1110) begin
        us++;
        chk("ovl1_units", 32'(bus.seg), 32'(dec_tab[cur.units]));
      end else begin
        ts++;
        chk("ovl1_tens", 32'({bus.an, bus.seg}), 32'(tens_drive(cur)));
      end
      tick();
    end
    chk("ovl_done2", 32'({bus.busy, bus.done}), 32'(2'b01));
    chk("ovl_slots_seen", 32'({us > 0, ts > 0}), 32'(2'b11));
    tick();
    pop_exp("ovl2", cur);
    check_display("ovl2", cur);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the third busy cycle aborts without a done pulse.
    pulse(5'd19);
    tick();
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 32'({bus.an, bus.seg, bus.dp, bus.busy, bus.done}),
        32'({4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0}));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("mid_no_done", 32'({bus.busy, bus.done}), 32'd0);
      tick();
    end
    check_display("mid", zero_exp);

    run_conv(5'd26, "v26");
    run_conv(5'd15, "v15");
    run_conv(5'd19, "v19");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/res_disp.md
Name: res_disp

Overview:
- Downstream consumer of the 4-bit operand comparator/adder stage. Takes its 5-bit result `s` (0..31) on a valid strobe.
- Converts the result to two BCD digits with an iterative shift-add-3 (double dabble) FSM.
- Drives a time-multiplexed, active-low 4-digit 7-segment display: units on digit 0, tens on digit 1, digits 2..3 always off.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit-scan period (bench uses 4); legal range 2..65535.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s  in  5  result from the comparator/adder stage; unsigned 0..31.
- s_valid  in  1  `s` is valid this cycle; single-cycle or held.
- busy  out  1  conversion in progress; `s_valid` ignored while high.
- done  out  1  one-cycle pulse when new digits are loaded into the display registers.
- an  out  4  digit anodes, active-low; an[0] units, an[1] tens.
- seg  out  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.
- dp  out  1  decimal point, active-low; tied 1 (off).

Behaviour:
- Reset (async assert, sync release) sets: state IDLE; busy=0; done=0; shift and BCD regs 0; display tens=0, units=0; scan counter 0; digit select = units; an=4'b1110; seg=7'b1000000; dp=1.
- FSM states are IDLE, CONV and LOAD.
- IDLE:
  - On an edge where s_valid=1, capture `s` into a 5-bit shift register and clear the BCD accumulator (tens 2b, units 4b).
  - Also clear the iteration counter, set busy=1 and go to CONV.
- CONV:
  - Runs 5 iterations, one per edge.
  - Each iteration: any BCD digit >=5 gets +3, then {tens,units,shift} shifts left 1.
  - The counter increments; after the 5th iteration go to LOAD.
- LOAD:
  - On the next edge, copy BCD into the display registers and set done=1 and busy=0 for exactly one cycle.
  - Return to IDLE.
- Latency: capture at edge E0; busy high for the cycles after E0..E5 (6 cycles); display updated and done high in the cycle after E6.
- An s_valid present in the done cycle is accepted, so back-to-back results are spaced 7 cycles apart.
- s_valid while busy=1 is ignored; no queueing, no error flag.
- Scan:
  - Free-running counter 0..SCAN_DIV-1, wrapping to 0.
  - On wrap, digit select toggles units<->tens.
  - Scan timing is not reset or resynchronised by a new result.
- Digit drive:
  - Units selected: an=1110, seg = decode(units).
  - Tens selected: an=1101, seg = decode(tens).
  - Leading-zero blanking: if tens=0, an=1111 and seg=1111111 during the tens slot.
  - an[3:2] are always 1.
- an/seg are registered: they change on the edge after a select toggle or a display-register update.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-conversion aborts cleanly to reset values; no done pulse.

Optional Feature:
- Macro: HEX_MODE_EN.
- When defined: LOAD loads tens={3'b000,s_cap[4]} and units=s_cap[3:0] from the originally captured value, i.e. hexadecimal display. The decoder covers A..F.
  - FSM timing, busy and done are identical to decimal mode: the CONV state still runs 5 cycles.
  - Leading-zero blanking still applies.
- When not defined: decimal BCD as above. Units never exceeds 9.

Test Plan:
- Reset: hold rst_n=0 -> an=1110, seg=1000000, dp=1, busy=0, done=0. Release; no change until s_valid.
- Decimal conversion: s=23, one-cycle s_valid (SCAN_DIV=4) -> busy=1 for 6 cycles, then done pulse 1 cycle.
  - Units slot: an=1110, seg=0110000.
  - Tens slot: an=1101, seg=0100100.
  - Slots alternate every 4 cycles.
- Blanking: s=7 -> units seg=1111000; tens slot an=1111, seg=1111111.
- Overlap: s=31 valid, then s=5 valid 3 cycles later (ignored), then s=10 valid in the done cycle.
  - First done shows 3/1.
  - Second done 7 cycles later shows 1/0.
  - The value 5 never appears.
- Reset mid-operation: s=19 valid, assert rst_n=0 during cycle 3 of busy -> immediate reset values; no done; display 0.
- HEX_MODE_EN: s=26 -> done after the same 7-cycle latency; tens=1 (seg=1111001), units=A (seg=0001000). s=15 -> tens blank, units F (seg=0001110).
